// File: rtl/bit_serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package bit_serial_adder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit counter must hold WIDTH-1 but never collapse to zero bits.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// Single-bit full adder cell; purely combinational, same a/b/c/sum/carry
// port set as the shared full-adder cell it stands in for.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ c;
  assign carry    = (a & b) | (c & half_sum);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: streams operands LSB-first through one full-adder cell,
// one bit per clock, carry held in a flip-flop between bits.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, a_sr_next;
  logic [WIDTH-1:0] b_sr_reg, b_sr_next;
  logic [WIDTH-1:0] sum_sr_reg, sum_sr_next;
  logic             c_reg, c_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] sum_out_reg, sum_out_next;
  logic             cout_reg, cout_next;

  logic             cell_sum;
  logic             cell_carry;
  logic [WIDTH-1:0] sum_shift;

  fa_cell u_cell (
    .a     (a_sr_reg[0]),
    .b     (b_sr_reg[0]),
    .c     (c_reg),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  // New sum bit enters at the MSB; the cast keeps this legal for WIDTH=1.
  assign sum_shift = WIDTH'({cell_sum, sum_sr_reg} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      a_sr_reg    <= '0;
      b_sr_reg    <= '0;
      sum_sr_reg  <= '0;
      c_reg       <= 1'b0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      sum_out_reg <= '0;
      cout_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_sr_reg    <= a_sr_next;
      b_sr_reg    <= b_sr_next;
      sum_sr_reg  <= sum_sr_next;
      c_reg       <= c_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      sum_out_reg <= sum_out_next;
      cout_reg    <= cout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_sr_next    = a_sr_reg;
    b_sr_next    = b_sr_reg;
    sum_sr_next  = sum_sr_reg;
    c_next       = c_reg;
    cnt_next     = cnt_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    sum_out_next = sum_out_reg;
    cout_next    = cout_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          a_sr_next   = a_in;
          b_sr_next   = b_in;
          c_next      = cin;
          cnt_next    = '0;
          sum_sr_next = '0;
          busy_next   = 1'b1;
          state_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sum_sr_next = sum_shift;
        c_next      = cell_carry;
        a_sr_next   = a_sr_reg >> 1;
        b_sr_next   = b_sr_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        // Last bit: publish result together with the final carry.
        if (cnt_reg == CNT_LAST) begin
          sum_out_next = sum_shift;
          cout_next    = cell_carry;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign sum_out = sum_out_reg;
  assign cout    = cout_reg;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances compared every cycle
// against a countdown/arithmetic reference model, plus literal expectations.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, cin1, busy1, done1, cout1, sum1;

  int checks = 0;
  int passed = 0;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
  );

  // Reference model: an accepted start schedules a+b+cin to appear WIDTH edges later.
  int         m8_rem;
  logic [8:0] m8_pend;
  logic       m8_busy, m8_done, m8_cout;
  logic [7:0] m8_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_rem <= 0; m8_pend <= '0; m8_busy <= 1'b0; m8_done <= 1'b0;
      m8_sum <= '0; m8_cout <= 1'b0;
    end else begin
      m8_done <= 1'b0;
      if (m8_rem == 0) begin
        if (start8) begin
          m8_rem  <= 8;
          m8_busy <= 1'b1;
          m8_pend <= 9'(a8) + 9'(b8) + 9'(cin8);
        end
      end else begin
        m8_rem <= m8_rem - 1;
        if (m8_rem == 1) begin
          m8_done           <= 1'b1;
          m8_busy           <= 1'b0;
          {m8_cout, m8_sum} <= m8_pend;
        end
      end
    end
  end

  int         m1_rem;
  logic [1:0] m1_pend;
  logic       m1_busy, m1_done, m1_cout, m1_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_rem <= 0; m1_pend <= '0; m1_busy <= 1'b0; m1_done <= 1'b0;
      m1_sum <= 1'b0; m1_cout <= 1'b0;
    end else begin
      m1_done <= 1'b0;
      if (m1_rem == 0) begin
        if (start1) begin
          m1_rem  <= 1;
          m1_busy <= 1'b1;
          m1_pend <= 2'(a1) + 2'(b1) + 2'(cin1);
        end
      end else begin
        m1_rem <= m1_rem - 1;
        if (m1_rem == 1) begin
          m1_done           <= 1'b1;
          m1_busy           <= 1'b0;
          {m1_cout, m1_sum} <= m1_pend;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic compare_all();
    chk("busy8", 32'(busy8), 32'(m8_busy));
    chk("done8", 32'(done8), 32'(m8_done));
    chk("sum8",  32'(sum8),  32'(m8_sum));
    chk("cout8", 32'(cout8), 32'(m8_cout));
    chk("busy1", 32'(busy1), 32'(m1_busy));
    chk("done1", 32'(done1), 32'(m1_done));
    chk("sum1",  32'(sum1),  32'(m1_sum));
    chk("cout1", 32'(cout1), 32'(m1_cout));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] es, input logic ec);
    int n;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(n);
    chk({name, "_latency"}, 32'(n), 32'd8);
    chk({name, "_sum"}, 32'(sum8), 32'(es));
    chk({name, "_cout"}, 32'(cout8), 32'(ec));
    $display("run %s: %02h + %02h + %0d -> sum=%02h cout=%0d after %0d cycles",
             name, a, b, c, sum8, cout8, n);
  endtask

  initial begin
    int n;
    logic [2:0] v;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) tick();
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_done8", 32'(done8), 32'd0);
    chk("reset_sum8",  32'(sum8),  32'd0);
    chk("reset_cout8", 32'(cout8), 32'd0);
    rst_n = 1'b1;
    tick();

    // WIDTH=1: every (a,b,cin) combination is one registered full add.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      chk("w1_done", 32'(done1), 32'd1);
      chk("w1_result", 32'({cout1, sum1}), 32'(v[2]) + 32'(v[1]) + 32'(v[0]));
      if (i == 7) chk("w1_111", 32'({cout1, sum1}), 32'h3);
      $display("w1 %0d+%0d+%0d -> cout=%0d sum=%0d", v[2], v[1], v[0], cout1, sum1);
    end

    run8("t2_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run8("t3_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("t3_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Starts during a run are ignored and do not disturb operands in flight.
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0; n = 0;
    tick(); tick(); n += 2;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    tick(); n++;
    start8 = 1'b0;
    tick(); n++;
    a8 = 8'h77; b8 = 8'h22; start8 = 1'b1;
    tick(); n++;
    start8 = 1'b0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_latency", 32'(n), 32'd8);
    chk("t4_sum", 32'(sum8), 32'h96);
    chk("t4_cout", 32'(cout8), 32'd0);
    $display("t4 ignored starts: sum=%02h cout=%0d after %0d cycles", sum8, cout8, n);

    // Start in the done cycle: accepted with no bubble, old result holds meanwhile.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t5_hold_sum", 32'(sum8), 32'h96);
      chk("t5_no_done", 32'(done8), 32'd0);
    end
    tick();
    chk("t5_done", 32'(done8), 32'd1);
    chk("t5_sum", 32'(sum8), 32'h31);
    $display("t5 back-to-back: sum=%02h done=%0d", sum8, done8);

    // Asynchronous reset in the middle of a run.
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy8), 32'd0);
    chk("t6_sum", 32'(sum8), 32'd0);
    chk("t6_cout", 32'(cout8), 32'd0);
    chk("t6_done", 32'(done8), 32'd0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_no_done", 32'(done8), 32'd0);
    end
    $display("t6 reset mid-run: busy=%0d sum=%02h", busy8, sum8);
    run8("t6_after", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // Random traffic on both instances, with operands changing while busy.
    for (int i = 0; i < 9000; i++) begin
      start8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      start1 = ($urandom_range(0, 1) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      tick();
      if (done8) $display("rand done8: sum=%02h cout=%0d", sum8, cout8);
    end
    start8 = 1'b0; start1 = 1'b0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
